nn_frame_master: RTL and testbench

//  Host-side end of the 256-byte-in / 10-byte-out UART inference protocol, for on-board loopback tests.

---
 rtl/nn_frame_master.sv | 171 +++++++++++++++++
 tb/tb_nn_frame_master.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/nn_frame_master.sv
// Host-side end of the UART inference protocol: streams a stored 256-byte frame out
// through a TX byte handshake, then collects the result bytes and tracks their signed argmax.
module nn_frame_master #(
  parameter int IN_BYTES       = 256,
  parameter int OUT_BYTES      = 10,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                   clk_100MHz,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   wr_en,
  input  logic [7:0]             wr_addr,
  input  logic [7:0]             wr_data,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout_err,
  output logic [OUT_BYTES*8-1:0] result_flat,
  output logic [3:0]             class_idx,
  output logic [7:0]             class_val
);

  localparam int NW = (IN_BYTES > 1) ? $clog2(IN_BYTES) : 1;
  localparam int MW = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

  state_t                 state_q, state_d;
  logic [NW-1:0]          n_q, n_d;
  logic [MW-1:0]          m_q, m_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic                   tx_valid_q, tx_valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   timeout_err_q, timeout_err_d;
  logic [OUT_BYTES*8-1:0] result_q, result_d;
  logic [3:0]             class_idx_q, class_idx_d;
  logic [7:0]             class_val_q, class_val_d;

  logic [7:0]             frame_buf_q [IN_BYTES];
  logic [NW-1:0]          n_next;
  logic [TW-1:0]          tmo_next;

  assign n_next   = n_q + NW'(1);
  assign tmo_next = tmo_q + TW'(1);

  // The frame buffer has no reset so a loaded frame survives an aborted transaction.
  always_ff @(posedge clk_100MHz) begin
    if (wr_en && (state_q == IDLE || state_q == DONE) && (32'(wr_addr) < IN_BYTES))
      frame_buf_q[wr_addr[NW-1:0]] <= wr_data;
  end

  always_comb begin
    state_d       = state_q;
    n_d           = n_q;
    m_d           = m_q;
    tmo_d         = tmo_q;
    tx_data_d     = tx_data_q;
    tx_valid_d    = tx_valid_q;
    busy_d        = busy_q;
    done_d        = done_q;
    timeout_err_d = timeout_err_q;
    result_d      = result_q;
    class_idx_d   = class_idx_q;
    class_val_d   = class_val_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d       = SEND;
          busy_d        = 1'b1;
          done_d        = 1'b0;
          timeout_err_d = 1'b0;
          result_d      = '0;
          class_idx_d   = '0;
          class_val_d   = '0;
          n_d           = '0;
          m_d           = '0;
          tmo_d         = '0;
          tx_valid_d    = 1'b1;
          tx_data_d     = frame_buf_q[0];
        end
      end
      SEND: begin
        if (tx_valid_q && tx_ready) begin
          if (n_q == NW'(IN_BYTES - 1)) begin
            tx_valid_d = 1'b0;
            state_d    = RECV;
            tmo_d      = '0;
          end else begin
            n_d       = n_next;
            tx_data_d = frame_buf_q[n_next];
          end
        end
      end
      RECV: begin
        // A byte arriving on the timeout cycle wins over the abort.
        if (rx_valid) begin
          for (int i = 0; i < OUT_BYTES; i++)
            if (m_q == MW'(i)) result_d[i*8 +: 8] = rx_data;
          if (m_q == '0 || $signed(rx_data) > $signed(class_val_q)) begin
            class_idx_d = 4'(m_q);
            class_val_d = rx_data;
          end
          m_d   = m_q + MW'(1);
          tmo_d = '0;
          if (m_q == MW'(OUT_BYTES - 1)) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          tmo_d = tmo_next;
          if (tmo_next == TW'(TIMEOUT_CYCLES)) begin
            state_d       = DONE;
            busy_d        = 1'b0;
            done_d        = 1'b1;
            timeout_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      state_q       <= IDLE;
      n_q           <= '0;
      m_q           <= '0;
      tmo_q         <= '0;
      tx_data_q     <= '0;
      tx_valid_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      result_q      <= '0;
      class_idx_q   <= '0;
      class_val_q   <= '0;
    end else begin
      state_q       <= state_d;
      n_q           <= n_d;
      m_q           <= m_d;
      tmo_q         <= tmo_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
      result_q      <= result_d;
      class_idx_q   <= class_idx_d;
      class_val_q   <= class_val_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = timeout_err_q;
  assign result_flat = result_q;
  assign class_idx   = class_idx_q;
  assign class_val   = class_val_q;

endmodule

// File: tb/tb_nn_frame_master.sv
// Directed bench for nn_frame_master: full-frame send, stalled send, argmax, timeout and reset abort.
module tb_nn_frame_master;

  logic        clk_100MHz = 1'b0;
  logic        rst, start, wr_en, tx_ready, rx_valid;
  logic [7:0]  wr_addr, wr_data, rx_data;
  logic [7:0]  tx_data, class_val;
  logic        tx_valid, busy, done, timeout_err;
  logic [79:0] result_flat;
  logic [3:0]  class_idx;

  int vectorCount = 0;
  int missCount   = 0;

  nn_frame_master #(.IN_BYTES(256), .OUT_BYTES(10), .TIMEOUT_CYCLES(100)) dut (
    .clk_100MHz (clk_100MHz),
    .rst        (rst),
    .start      (start),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .busy       (busy),
    .done       (done),
    .timeout_err(timeout_err),
    .result_flat(result_flat),
    .class_idx  (class_idx),
    .class_val  (class_val)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic checkOutput(input string tag, input logic [79:0] observed, input logic [79:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Inputs change 1 ns after a rising edge and outputs are sampled at the same point.
  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge clk_100MHz);
      #1;
    end
  endtask

  task automatic writeByte(input logic [7:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    applyStimulus(1);
    wr_en = 1'b0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    applyStimulus(1);
    start = 1'b0;
  endtask

  task automatic recvByte(input logic [7:0] d);
    rx_valid = 1'b1; rx_data = d;
    applyStimulus(1);
    rx_valid = 1'b0;
  endtask

  // Frame bytes are expected to be i ^ mask, accepted back to back with tx_ready held high.
  task automatic sendFullFrame(input logic [7:0] mask);
    logic [7:0] nb;
    tx_ready = 1'b1;
    for (int n = 0; n < 256; n++) begin
      nb = n[7:0];
      checkOutput("tx_byte", {71'd0, tx_valid, tx_data}, {71'd0, 1'b1, nb ^ mask});
      applyStimulus(1);
    end
    checkOutput("tx_valid_after_send", {79'd0, tx_valid}, 80'd0);
    checkOutput("busy_in_recv", {79'd0, busy}, 80'd1);
  endtask

  initial begin
    logic [7:0]  resBytes [10];
    logic [79:0] expFlat;
    logic [7:0]  nb;
    int          n, cyc;

    rst = 1'b1; start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    applyStimulus(2);
    checkOutput("rst_tx_valid", {79'd0, tx_valid}, 80'd0);
    checkOutput("rst_tx_data", {72'd0, tx_data}, 80'd0);
    checkOutput("rst_flags", {77'd0, busy, done, timeout_err}, 80'd0);
    checkOutput("rst_result", result_flat, 80'd0);
    checkOutput("rst_class", {68'd0, class_idx, class_val}, 80'd0);
    rst = 1'b0;

    // Incrementing frame, free-running sink, then results with a tie on 0x7F.
    for (int i = 0; i < 256; i++) writeByte(8'(i), 8'(i));
    pulseStart();
    checkOutput("start_busy_done", {78'd0, busy, done}, 80'd2);
    sendFullFrame(8'h00);
    resBytes = '{8'h05, 8'h7F, 8'h80, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    expFlat = '0;
    for (int i = 0; i < 10; i++) begin
      expFlat[i*8 +: 8] = resBytes[i];
      if (i == 9) checkOutput("done_before_last", {79'd0, done}, 80'd0);
      recvByte(resBytes[i]);
    end
    checkOutput("t1_done_busy_tmo", {77'd0, done, busy, timeout_err}, 80'b100);
    checkOutput("t1_result", result_flat, expFlat);
    checkOutput("t1_class_idx", {76'd0, class_idx}, 80'd1);
    checkOutput("t1_class_val", {72'd0, class_val}, 80'h7F);
    applyStimulus(3);
    checkOutput("t1_done_level", {79'd0, done}, 80'd1);

    // Inverted frame loaded from DONE, sink ready one cycle in three; start, wr and rx mid-send are ignored.
    for (int i = 0; i < 256; i++) writeByte(8'(i), ~8'(i));
    pulseStart();
    n = 0; cyc = 0;
    while (n < 256 && cyc < 2000) begin
      tx_ready = (cyc % 3 == 0);
      if (cyc == 10) begin
        rx_valid = 1'b1; rx_data = 8'h55; start = 1'b1;
        wr_en = 1'b1; wr_addr = 8'h00; wr_data = 8'hAA;
      end
      nb = n[7:0];
      checkOutput("tx_present", {71'd0, tx_valid, tx_data}, {71'd0, 1'b1, ~nb});
      applyStimulus(1);
      rx_valid = 1'b0; start = 1'b0; wr_en = 1'b0;
      if (tx_ready) n++;
      cyc++;
    end
    checkOutput("t2_bytes_sent", 80'(n), 80'd256);
    checkOutput("t2_tx_valid_after", {79'd0, tx_valid}, 80'd0);
    tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      recvByte(8'hF0);
      applyStimulus(i % 3);
    end
    checkOutput("t2_done_busy_tmo", {77'd0, done, busy, timeout_err}, 80'b100);
    checkOutput("t2_result", result_flat, {10{8'hF0}});
    checkOutput("t2_class_idx", {76'd0, class_idx}, 80'd0);
    checkOutput("t2_class_val", {72'd0, class_val}, 80'hF0);

    // Timeout: a byte on the 100th idle cycle rescues the transfer, the next silence aborts it.
    pulseStart();
    sendFullFrame(8'hFF);
    recvByte(8'h10); recvByte(8'h80); recvByte(8'h20);
    applyStimulus(99);
    checkOutput("t3_alive_99", {78'd0, done, busy}, 80'b01);
    recvByte(8'h30);
    checkOutput("t3_rescued", {77'd0, done, busy, timeout_err}, 80'b010);
    applyStimulus(99);
    checkOutput("t3_alive_again", {78'd0, done, busy}, 80'b01);
    applyStimulus(1);
    checkOutput("t3_timeout", {77'd0, done, busy, timeout_err}, 80'b101);
    checkOutput("t3_result", result_flat, {48'd0, 8'h30, 8'h20, 8'h80, 8'h10});
    checkOutput("t3_class_idx", {76'd0, class_idx}, 80'd3);
    checkOutput("t3_class_val", {72'd0, class_val}, 80'h30);

    // Reset in the middle of the send, then a fresh start resends from buf[0].
    pulseStart();
    checkOutput("t4_start_clears", {78'd0, done, timeout_err}, 80'd0);
    tx_ready = 1'b1;
    applyStimulus(40);
    checkOutput("t4_byte40", {71'd0, tx_valid, tx_data}, {71'd0, 1'b1, 8'hD7});
    rst = 1'b1;
    applyStimulus(1);
    rst = 1'b0;
    checkOutput("t4_rst_flags", {76'd0, tx_valid, busy, done, timeout_err}, 80'd0);
    checkOutput("t4_rst_result", result_flat, 80'd0);
    pulseStart();
    checkOutput("t4_restart", {70'd0, busy, tx_valid, tx_data}, {70'd0, 2'b11, 8'hFF});
    applyStimulus(1);
    checkOutput("t4_restart_next", {71'd0, tx_valid, tx_data}, {71'd0, 1'b1, 8'hFE});

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed no completion, expected finish within 1 ms");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
